templatized_alu_sequencer: RTL and testbench
============================================

Name: templatized_alu_sequencer

Overview:
Multi-cycle successor to the ALU op decoder. Accepts one op per transaction over a valid/ready handshake and decodes it to per-unit enables. It issues a one-cycle enable pulse, tracks the per-unit latency with a countdown counter, and returns a tagged completion over a second valid/ready handshake. Sits between the issue stage and the three ALU sub-units (U2 = add/logic, U1 = mul, U0 = shift/compare). Illegal ops are flagged and counted, never issued.

Parameters:
OP_W, 4, op code width; must be >= 4; any nonzero bit above bit 3 makes the op illegal
TAG_W, 4, transaction tag width
LAT_W, 4, latency field width
LAT_U2, 1, U2 latency in cycles (0 is treated as 1)
LAT_U1, 3, U1 latency in cycles (0 is treated as 1)
LAT_U0, 2, U0 latency in cycles (0 is treated as 1)
CNT_W, 8, illegal-op counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  op request valid
op_ready  output  1  op accepted when op_valid && op_ready
op_code  input  OP_W  operation code
op_tag  input  TAG_W  tag returned with completion
flush  input  1  synchronous abort, active high
unit_en  output  3  {U2,U1,U0} one-cycle enable pulse, registered
busy  output  1  high whenever state != IDLE
done_valid  output  1  completion valid
done_ready  input  1  completion consumed when done_valid && done_ready
done_tag  output  TAG_W  tag of the completed op
done_err  output  1  completed op was illegal
illegal_cnt  output  CNT_W  saturating count of illegal ops

Behaviour:
- Reset (async, rst_n=0): state=IDLE; unit_en=0, done_valid=0, done_tag=0, done_err=0, illegal_cnt=0, busy=0. Takes effect immediately, including mid-operation. No enable pulse or completion is emitted for an op in flight.
- Decode, bits [3:0], upper bits zero:
  - 0000, 0001, 0010 -> 100
  - 0100 -> 110
  - 0101 -> 010
  - 0110, 0111, 1000, 1001 -> 001
  - all else illegal
- Op latency L = max latency over the enabled units (op 0100 -> max(LAT_U2, LAT_U1)).
- op_ready = (state==IDLE) && !flush. op_ready is combinational from state and flush.
- States: IDLE, ISSUE, EXEC, DONE.
- IDLE, accept at edge T:
  - Capture tag.
  - Legal op -> ISSUE.
  - Illegal op -> DONE with done_err=1. illegal_cnt increments, saturating at all-ones.
- ISSUE (cycle T+1): unit_en = decoded vector for exactly this cycle. Counter loads L. If L==1 -> DONE next; else -> EXEC.
- EXEC: counter decrements each cycle; at counter==2 -> DONE next.
- Timing: done_valid rises at cycle T+1+L for legal ops and T+1 for illegal ops.
- DONE: done_valid=1; done_tag and done_err are held stable until done_ready. On handshake -> IDLE, and done_valid=0 next cycle. There is no overlap: a new op is accepted at the earliest one cycle after the done handshake.
- flush: highest priority synchronous event. In any state -> IDLE next cycle.
  - done_valid and unit_en are 0 from the next cycle.
  - A pending completion is dropped.
  - illegal_cnt is not changed, except that an illegal op accepted in the same cycle is impossible because op_ready=0 under flush.
- Simultaneous flush and done handshake: flush wins. Both yield IDLE; nothing else changes.
- unit_en is 0 in every state except ISSUE.
- done_tag/done_err keep their last values outside DONE and are valid only with done_valid.

Test Plan:
- Reset, then op 0000 tag 5 accepted at T with done_ready=1 -> unit_en=100 only at T+1; done_valid at T+2 with done_tag=5, done_err=0; op_ready returns at T+3.
- Op 0100 tag 3 (defaults) -> unit_en=110 at T+1; done_valid at T+4; busy high T+1..T+4.
- Op 0011 tag 9 -> unit_en stays 000; done_valid at T+1 with done_err=1, tag 9; illegal_cnt=1. With CNT_W=2, 5 illegal ops -> illegal_cnt=3 (saturated).
- Op 0110, done_ready held low 5 cycles -> done_valid, done_tag and done_err stable throughout; a second op_valid is not accepted (op_ready=0) until the cycle after the done handshake.
- Op 0101 (L=3), flush asserted in the first EXEC cycle -> IDLE next cycle; no done_valid ever; op_ready=1 once flush deasserts.
- Op 1001 accepted, rst_n pulled low during EXEC -> unit_en, done_valid and busy go to 0 without waiting for a clock edge; after release, illegal_cnt=0 and op_ready=1.

Source files
------------

// File: rtl/templatized_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// templatized_alu_sequencer_if
//   Issue and completion handshakes of the ALU sequencer.
//
//   Both handshakes use the same rule: a transfer happens on a rising clock
//   edge where valid && ready are both high. valid, once raised, and the
//   payload that goes with it stay unchanged until that transfer.
//
//   op_valid   : issue stage has an op to hand over
//   op_ready   : sequencer can take an op this cycle
//   op_code    : operation code (OP_W bits)
//   op_tag     : tag returned with the completion (TAG_W bits)
//   done_valid : sequencer holds a completion
//   done_ready : consumer takes the completion this cycle
//   done_tag   : tag of the completed op
//   done_err   : completed op was illegal
//
//   master : issue/consumer side       slave : sequencer side
// ---------------------------------------------------------------------------
interface templatized_alu_sequencer_if #(
    parameter int OP_W  = 4,
    parameter int TAG_W = 4
);
    logic             op_valid;
    logic             op_ready;
    logic [OP_W-1:0]  op_code;
    logic [TAG_W-1:0] op_tag;
    logic             done_valid;
    logic             done_ready;
    logic [TAG_W-1:0] done_tag;
    logic             done_err;

    modport master (
        output op_valid, op_code, op_tag, done_ready,
        input  op_ready, done_valid, done_tag, done_err
    );

    modport slave (
        input  op_valid, op_code, op_tag, done_ready,
        output op_ready, done_valid, done_tag, done_err
    );
endinterface

// File: rtl/templatized_alu_sequencer.sv
// ---------------------------------------------------------------------------
// templatized_alu_sequencer
//   Takes one ALU op at a time, decodes it to the {U2,U1,U0} unit enables,
//   pulses the enables for one cycle, waits out the slowest enabled unit's
//   latency and returns a tagged completion. Illegal ops skip issue, complete
//   immediately with done_err=1 and bump a saturating counter.
//
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   bus         : issue/completion handshakes (slave modport)
//   flush       : synchronous abort, highest priority
//   unit_en     : {U2,U1,U0} one-cycle enable pulse (registered)
//   busy        : sequencer not idle
//   illegal_cnt : saturating count of illegal ops
//   o_dbg_state : current FSM state (IDLE=0, ISSUE=1, EXEC=2, DONE=3)
// ---------------------------------------------------------------------------
module templatized_alu_sequencer #(
    parameter int OP_W   = 4,
    parameter int TAG_W  = 4,
    parameter int LAT_W  = 4,
    parameter int LAT_U2 = 1,
    parameter int LAT_U1 = 3,
    parameter int LAT_U0 = 2,
    parameter int CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    templatized_alu_sequencer_if.slave    bus,
    input  logic                          flush,
    output logic [2:0]                    unit_en,
    output logic                          busy,
    output logic [CNT_W-1:0]              illegal_cnt,
    output logic [1:0]                    o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A zero latency parameter still costs one cycle.
    localparam logic [LAT_W-1:0] C_LAT_U2 = (LAT_U2 == 0) ? LAT_W'(1) : LAT_W'(LAT_U2);
    localparam logic [LAT_W-1:0] C_LAT_U1 = (LAT_U1 == 0) ? LAT_W'(1) : LAT_W'(LAT_U1);
    localparam logic [LAT_W-1:0] C_LAT_U0 = (LAT_U0 == 0) ? LAT_W'(1) : LAT_W'(LAT_U0);

    state_t             r_state;
    logic [2:0]         r_unit_en;
    logic [LAT_W-1:0]   r_lat;
    logic [LAT_W-1:0]   r_cnt;
    logic               r_done_valid;
    logic [TAG_W-1:0]   r_done_tag;
    logic               r_done_err;
    logic [CNT_W-1:0]   r_illegal_cnt;

    logic               w_upper_nz;
    logic [2:0]         w_dec;
    logic               w_legal;
    logic [LAT_W-1:0]   w_lat;
    logic               w_accept;

    // Any set bit above bit 3 makes the op illegal.
    generate
        if (OP_W > 4) begin : g_upper
            assign w_upper_nz = |bus.op_code[OP_W-1:4];
        end else begin : g_no_upper
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        w_dec = 3'b000;
        case (bus.op_code[3:0])
            4'b0000, 4'b0001, 4'b0010:          w_dec = 3'b100;
            4'b0100:                            w_dec = 3'b110;
            4'b0101:                            w_dec = 3'b010;
            4'b0110, 4'b0111, 4'b1000, 4'b1001: w_dec = 3'b001;
            default:                            w_dec = 3'b000;
        endcase
        if (w_upper_nz) begin
            w_dec = 3'b000;
        end
    end

    assign w_legal = (w_dec != 3'b000);

    // Op latency is that of the slowest unit it enables.
    always_comb begin
        w_lat = '0;
        if (w_dec[2] && (C_LAT_U2 > w_lat)) w_lat = C_LAT_U2;
        if (w_dec[1] && (C_LAT_U1 > w_lat)) w_lat = C_LAT_U1;
        if (w_dec[0] && (C_LAT_U0 > w_lat)) w_lat = C_LAT_U0;
    end

    assign bus.op_ready = (r_state == S_IDLE) && !flush;
    assign w_accept     = bus.op_valid && bus.op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_unit_en     <= 3'b000;
            r_lat         <= '0;
            r_cnt         <= '0;
            r_done_valid  <= 1'b0;
            r_done_tag    <= '0;
            r_done_err    <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            // The enable is a single-cycle pulse: raised on the accept edge
            // so it is visible exactly during ISSUE, dropped on the next edge.
            r_unit_en <= 3'b000;
            if (flush) begin
                r_state      <= S_IDLE;
                r_done_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_done_tag <= bus.op_tag;
                            if (w_legal) begin
                                r_state    <= S_ISSUE;
                                r_unit_en  <= w_dec;
                                r_lat      <= w_lat;
                                r_done_err <= 1'b0;
                            end else begin
                                r_state      <= S_DONE;
                                r_done_valid <= 1'b1;
                                r_done_err   <= 1'b1;
                                if (r_illegal_cnt != {CNT_W{1'b1}}) begin
                                    r_illegal_cnt <= r_illegal_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    S_ISSUE: begin
                        r_cnt <= r_lat;
                        if (r_lat == LAT_W'(1)) begin
                            r_state      <= S_DONE;
                            r_done_valid <= 1'b1;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        // Leaving at count 2 puts done_valid L cycles after ISSUE.
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == LAT_W'(2)) begin
                            r_state      <= S_DONE;
                            r_done_valid <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (bus.done_ready) begin
                            r_state      <= S_IDLE;
                            r_done_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign unit_en        = r_unit_en;
    assign busy           = (r_state != S_IDLE);
    assign illegal_cnt    = r_illegal_cnt;
    assign o_dbg_state    = r_state;
    assign bus.done_valid = r_done_valid;
    assign bus.done_tag   = r_done_tag;
    assign bus.done_err   = r_done_err;

endmodule

// File: tb/tb_templatized_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_templatized_alu_sequencer
//   Directed and randomized ops against a table-driven reference of the
//   decode, latency and completion timing. OP_W=5 exercises the upper-bit
//   illegal rule, CNT_W=2 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_templatized_alu_sequencer;

    localparam int OP_W   = 5;
    localparam int TAG_W  = 4;
    localparam int LAT_W  = 4;
    localparam int LAT_U2 = 1;
    localparam int LAT_U1 = 3;
    localparam int LAT_U0 = 2;
    localparam int CNT_W  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             flush;
    logic [2:0]       unit_en;
    logic             busy;
    logic [CNT_W-1:0] illegal_cnt;
    logic [1:0]       dbg_state;

    templatized_alu_sequencer_if #(.OP_W(OP_W), .TAG_W(TAG_W)) bus ();

    templatized_alu_sequencer #(
        .OP_W(OP_W), .TAG_W(TAG_W), .LAT_W(LAT_W),
        .LAT_U2(LAT_U2), .LAT_U1(LAT_U1), .LAT_U0(LAT_U0), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush       (flush),
        .unit_en     (unit_en),
        .busy        (busy),
        .illegal_cnt (illegal_cnt),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    logic [TAG_W:0] exp_q[$];   // {err, tag} of each accepted op

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_en(input int op);
        if (op > 15) return 3'b000;
        case (op)
            0, 1, 2:    return 3'b100;
            4:          return 3'b110;
            5:          return 3'b010;
            6, 7, 8, 9: return 3'b001;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic int eff(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int ref_lat(input logic [2:0] en);
        int l = 0;
        if (en[2] && eff(LAT_U2) > l) l = eff(LAT_U2);
        if (en[1] && eff(LAT_U1) > l) l = eff(LAT_U1);
        if (en[0] && eff(LAT_U0) > l) l = eff(LAT_U0);
        return l;
    endfunction

    function automatic int sat_inc(input int c);
        return (c == (1 << CNT_W) - 1) ? c : c + 1;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic accept_op(input int op, input int tag);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_W'(op);
        bus.op_tag   = TAG_W'(tag);
        #1;
        check("op_ready_idle", 32'(bus.op_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    // Full transaction: issue, check timing each cycle, hold done_ready low
    // for 'hold' cycles while also offering a second op, then complete.
    task automatic run_op(input int op, input int tag, input int hold);
        logic [2:0]     en;
        logic           legal;
        int             done_k;
        logic [TAG_W:0] exp;
        en     = ref_en(op);
        legal  = (en != 3'b000);
        done_k = legal ? 1 + ref_lat(en) : 1;
        exp_q.push_back({~legal, TAG_W'(tag)});
        accept_op(op, tag);
        if (!legal) model_cnt = sat_inc(model_cnt);
        for (int k = 1; k <= done_k; k++) begin
            if (k > 1) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("unit_en", 32'(unit_en), (k == 1 && legal) ? 32'(en) : 32'd0);
            check("done_valid_timing", 32'(bus.done_valid), (k == done_k) ? 32'd1 : 32'd0);
            check("busy", 32'(busy), 32'd1);
            check("illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
        end
        exp = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            bus.done_ready = (h == hold);
            bus.op_valid   = (h < hold);
            bus.op_code    = '0;
            #1;
            check("op_ready_in_done", 32'(bus.op_ready), 32'd0);
            check("done_valid_hold", 32'(bus.done_valid), 32'd1);
            check("done_tag", 32'(bus.done_tag), 32'(exp[TAG_W-1:0]));
            check("done_err", 32'(bus.done_err), 32'(exp[TAG_W]));
            @(posedge clk);
            @(negedge clk);
        end
        bus.done_ready = 1'b0;
        bus.op_valid   = 1'b0;
        #1;
        check("done_valid_drop", 32'(bus.done_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("op_ready_back", 32'(bus.op_ready), 32'd1);
        @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int op;
        bus.op_valid   = 1'b0;
        bus.op_code    = '0;
        bus.op_tag     = '0;
        bus.done_ready = 1'b0;
        flush          = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_unit_en", 32'(unit_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_done_valid", 32'(bus.done_valid), 32'd0);
        check("rst_done_tag", 32'(bus.done_tag), 32'd0);
        check("rst_done_err", 32'(bus.done_err), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("rst_op_ready", 32'(bus.op_ready), 32'd1);

        // Basic legal ops
        run_op(0, 5, 0);
        run_op(4, 3, 0);
        run_op(3, 9, 0);
        check("illegal_cnt_one", 32'(illegal_cnt), 32'd1);

        // Saturation: five more illegal ops, including upper-bit illegal
        run_op(10, 1, 0);
        run_op(16, 2, 1);
        run_op(15, 3, 0);
        run_op(20, 4, 0);
        run_op(12, 6, 0);
        check("illegal_cnt_sat", 32'(illegal_cnt), 32'd3);

        // Backpressure on completion
        run_op(6, 4, 5);

        // Flush in the first EXEC cycle of op 0101
        accept_op(5, 2);
        check("flush_unit_en", 32'(unit_en), 32'b010);
        @(posedge clk);
        @(negedge clk);
        check("flush_busy_exec", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_unit_en_zero", 32'(unit_en), 32'd0);
        check("flush_op_ready", 32'(bus.op_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_no_done", 32'(bus.done_valid), 32'd0);
        end

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_code  = '0;
        #1;
        check("flush_idle_op_ready", 32'(bus.op_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        bus.op_valid = 1'b0;
        check("flush_idle_no_accept", 32'(busy), 32'd0);

        // Flush together with done handshake on an illegal op
        accept_op(13, 8);
        model_cnt = sat_inc(model_cnt);
        check("flushdone_valid", 32'(bus.done_valid), 32'd1);
        flush = 1'b1;
        bus.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        bus.done_ready = 1'b0;
        check("flushdone_drop", 32'(bus.done_valid), 32'd0);
        check("flushdone_busy", 32'(busy), 32'd0);
        check("flushdone_cnt", 32'(illegal_cnt), 32'(model_cnt));
        @(negedge clk);

        // Async reset during ISSUE
        accept_op(4, 1);
        check("rst_issue_en_before", 32'(unit_en), 32'b110);
        #2 rst_n = 1'b0;
        #1;
        check("rst_issue_unit_en", 32'(unit_en), 32'd0);
        check("rst_issue_busy", 32'(busy), 32'd0);
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset during EXEC of op 1001
        accept_op(9, 7);
        check("rst_exec_unit_en_issue", 32'(unit_en), 32'b001);
        @(posedge clk);
        @(negedge clk);
        check("rst_exec_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec_unit_en", 32'(unit_en), 32'd0);
        check("rst_exec_done_valid", 32'(bus.done_valid), 32'd0);
        check("rst_exec_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_exec_cnt", 32'(illegal_cnt), 32'd0);
        check("rst_exec_op_ready", 32'(bus.op_ready), 32'd1);

        // Randomized ops
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) op = int'($urandom_range(16, 31));
            else op = int'($urandom_range(0, 15));
            run_op(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
